// File: rtl/mem_align_pkg.sv
// Shared encodings for the load/store alignment unit: access-size codes,
// FSM state enum and a size-to-byte-count helper.
package mem_align_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_DWORD = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BEAT0,
    ST_BEAT1,
    ST_WAIT,
    ST_RESP
  } state_t;

  function automatic int size_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE:  return 1;
      SZ_HALF:  return 2;
      SZ_WORD:  return 4;
      SZ_DWORD: return 8;
      default:  return 1;
    endcase
  endfunction

endpackage

// File: rtl/mem_align_if.sv
// Request / data-memory / response bundle between execute, the alignment unit
// and the data-memory port. The unit uses the slave view, its environment the master view.
interface mem_align_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
);
  localparam int BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic              kill;
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic [BYTES-1:0]  mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic [TAG_W-1:0]  rsp_tag;

  modport slave (
    input  req_valid, req_store, req_size, req_signed, req_addr, req_wdata, req_tag, kill,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, mem_req, mem_addr, mem_we, mem_wdata, rsp_valid, rsp_data, rsp_tag
  );

  modport master (
    output req_valid, req_store, req_size, req_signed, req_addr, req_wdata, req_tag, kill,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, mem_req, mem_addr, mem_we, mem_wdata, rsp_valid, rsp_data, rsp_tag
  );

endinterface

// File: rtl/mem_lane_shifter.sv
// Combinational lane mapper: places store data into bus lanes for beat 0/1, or
// pulls the lanes of a read beat back down into access-relative byte order.
module mem_lane_shifter
  import mem_align_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [$clog2(DATA_W/8)-1:0] offset,
  input  logic [1:0]                  size,
  input  logic                        beat,
  input  logic                        extract,
  input  logic [DATA_W-1:0]           data_in,
  output logic [DATA_W/8-1:0]         strobes,
  output logic [DATA_W-1:0]           data_out
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam logic [2*BYTES-1:0] ONE = 1;

  int                  n;
  logic [2*BYTES-1:0]  lane_wide;
  logic [DATA_W-1:0]   size_mask;
  logic [DATA_W-1:0]   lane_mask;
  logic [2*DATA_W-1:0] wide;
  logic [OFF_W+2:0]    bit_off;

  // The access is viewed as a two-word window so both beats fall out of one shift.
  always_comb begin
    n         = size_bytes(size);
    bit_off   = {offset, 3'b000};
    lane_wide = ((ONE << n) - ONE) << offset;
    strobes   = beat ? lane_wide[2*BYTES-1:BYTES] : lane_wide[BYTES-1:0];
    size_mask = '0;
    lane_mask = '0;
    for (int i = 0; i < BYTES; i++) begin
      size_mask[8*i +: 8] = (i < n) ? 8'hFF : 8'h00;
      lane_mask[8*i +: 8] = {8{strobes[i]}};
    end
    if (extract) begin
      wide = beat ? {data_in & lane_mask, {DATA_W{1'b0}}}
                  : {{DATA_W{1'b0}}, data_in & lane_mask};
      wide = wide >> bit_off;
    end else begin
      wide = {{DATA_W{1'b0}}, data_in & size_mask} << bit_off;
    end
    data_out = (beat && !extract) ? wide[2*DATA_W-1:DATA_W] : wide[DATA_W-1:0];
  end

endmodule

// File: rtl/mem_align_unit.sv
// Load/store alignment engine: splits boundary-crossing accesses into two aligned
// beats, merges and extends load data, and returns a tagged completion pulse.
module mem_align_unit
  import mem_align_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 5
) (
  input logic        clk,
  input logic        rst_n,
  mem_align_if.slave bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);

  state_t            state;
  logic              ready_q, mem_req_q, rsp_valid_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BYTES-1:0]  mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q, rsp_data_q, op_wdata, merge_buf;
  logic [TAG_W-1:0]  rsp_tag_q, op_tag;
  logic              op_store, op_signed, op_split, killed, rd_beat;
  logic [1:0]        op_size, out_cnt, cnt_next;
  logic [OFF_W-1:0]  op_off;

  logic [OFF_W-1:0]  sh_off;
  logic [1:0]        sh_size;
  logic              sh_beat, sh_extract;
  logic [DATA_W-1:0] sh_data, sh_out;
  logic [BYTES-1:0]  sh_strobes;

  logic              accept, req_legal, req_split, rd_hit, load_gnt, kill_any;
  logic [DATA_W-1:0] merged, ext_data;
  int                ext_n;
  logic              sign_bit;

  // In IDLE the shifter prepares beat 0 of the offered request; afterwards a store
  // needs it for beat 1 and a load needs it to extract each returning read beat.
  always_comb begin
    sh_off     = op_off;
    sh_size    = op_size;
    sh_beat    = rd_beat;
    sh_extract = 1'b1;
    sh_data    = bus.mem_rdata;
    if (state == ST_IDLE) begin
      sh_off     = bus.req_addr[OFF_W-1:0];
      sh_size    = bus.req_size;
      sh_beat    = 1'b0;
      sh_extract = 1'b0;
      sh_data    = bus.req_wdata;
    end else if (op_store) begin
      sh_beat    = 1'b1;
      sh_extract = 1'b0;
      sh_data    = op_wdata;
    end
  end

  mem_lane_shifter #(.DATA_W(DATA_W)) u_shifter (
    .offset   (sh_off),
    .size     (sh_size),
    .beat     (sh_beat),
    .extract  (sh_extract),
    .data_in  (sh_data),
    .strobes  (sh_strobes),
    .data_out (sh_out)
  );

  assign accept    = bus.req_valid && ready_q && !bus.kill;
  assign req_legal = int'(bus.req_size) <= OFF_W;
  assign req_split = (int'(bus.req_addr[OFF_W-1:0]) + size_bytes(bus.req_size)) > BYTES;
  assign rd_hit    = bus.mem_rvalid && (out_cnt != 2'd0);
  assign load_gnt  = bus.mem_gnt && !op_store && (state == ST_BEAT0 || state == ST_BEAT1);
  assign cnt_next  = out_cnt + {1'b0, load_gnt} - {1'b0, rd_hit};
  assign merged    = rd_hit ? (merge_buf | sh_out) : merge_buf;
  assign kill_any  = killed || bus.kill;

  always_comb begin
    ext_n    = size_bytes(op_size);
    sign_bit = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      if (i == ext_n - 1) sign_bit = merged[8*i+7];
    end
    sign_bit = sign_bit & op_signed;
    for (int i = 0; i < BYTES; i++) begin
      ext_data[8*i +: 8] = (i < ext_n) ? merged[8*i +: 8] : {8{sign_bit}};
    end
  end

  // A kill seen after the first grant only suppresses the response; granted
  // work is always finished so memory never sees a partial store.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ready_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      out_cnt     <= '0;
      merge_buf   <= '0;
      rd_beat     <= 1'b0;
      killed      <= 1'b0;
      op_store    <= 1'b0;
      op_signed   <= 1'b0;
      op_split    <= 1'b0;
      op_size     <= '0;
      op_off      <= '0;
      op_tag      <= '0;
      op_wdata    <= '0;
    end else begin
      out_cnt <= cnt_next;
      if (rd_hit) begin
        merge_buf <= merged;
        rd_beat   <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_store  <= bus.req_store;
            op_signed <= bus.req_signed;
            op_split  <= req_split;
            op_size   <= bus.req_size;
            op_off    <= bus.req_addr[OFF_W-1:0];
            op_tag    <= bus.req_tag;
            op_wdata  <= bus.req_wdata;
            killed    <= 1'b0;
            merge_buf <= '0;
            rd_beat   <= 1'b0;
            ready_q   <= 1'b0;
            if (!req_legal) begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_tag_q   <= bus.req_tag;
            end else begin
              state       <= ST_BEAT0;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_we_q    <= bus.req_store ? sh_strobes : '0;
              mem_wdata_q <= bus.req_store ? sh_out : '0;
            end
          end
        end
        ST_BEAT0: begin
          if (bus.mem_gnt) begin
            if (bus.kill) killed <= 1'b1;
            if (op_split) begin
              state       <= ST_BEAT1;
              mem_addr_q  <= mem_addr_q + ADDR_W'(BYTES);
              mem_we_q    <= op_store ? sh_strobes : '0;
              mem_wdata_q <= op_store ? sh_out : '0;
            end else begin
              mem_req_q <= 1'b0;
              mem_we_q  <= '0;
              if (!op_store) begin
                state <= ST_WAIT;
              end else if (kill_any) begin
                state   <= ST_IDLE;
                ready_q <= 1'b1;
              end else begin
                state       <= ST_RESP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
                rsp_tag_q   <= op_tag;
              end
            end
          end else if (bus.kill) begin
            state     <= ST_IDLE;
            ready_q   <= 1'b1;
            mem_req_q <= 1'b0;
            mem_we_q  <= '0;
          end
        end
        ST_BEAT1: begin
          if (bus.kill) killed <= 1'b1;
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= '0;
            if (!op_store) begin
              state <= ST_WAIT;
            end else if (kill_any) begin
              state   <= ST_IDLE;
              ready_q <= 1'b1;
            end else begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= '0;
              rsp_tag_q   <= op_tag;
            end
          end
        end
        ST_WAIT: begin
          if (bus.kill) killed <= 1'b1;
          if (cnt_next == 2'd0) begin
            if (kill_any) begin
              state   <= ST_IDLE;
              ready_q <= 1'b1;
            end else begin
              state       <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= ext_data;
              rsp_tag_q   <= op_tag;
            end
          end
        end
        ST_RESP: begin
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = ready_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_mem_align_unit.sv
// Bench for mem_align_unit: 32- and 64-bit instances driven through one shared
// stimulus path and checked against a byte-address reference model.
module tb_mem_align_unit;
  import mem_align_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel64;
  logic        req_valid, req_store, req_signed, kill, mem_gnt, mem_rvalid;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata, mem_rdata;
  logic [4:0]  req_tag;

  int checks   = 0;
  int failures = 0;

  mem_align_if #(.DATA_W(32), .ADDR_W(32), .TAG_W(5)) bus32 ();
  mem_align_if #(.DATA_W(64), .ADDR_W(32), .TAG_W(5)) bus64 ();

  mem_align_unit #(.DATA_W(32), .ADDR_W(32), .TAG_W(5)) dut32 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus32)
  );

  mem_align_unit #(.DATA_W(64), .ADDR_W(32), .TAG_W(5)) dut64 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus64)
  );

  assign bus32.req_valid  = req_valid & ~sel64;
  assign bus32.req_store  = req_store;
  assign bus32.req_size   = req_size;
  assign bus32.req_signed = req_signed;
  assign bus32.req_addr   = req_addr;
  assign bus32.req_wdata  = req_wdata[31:0];
  assign bus32.req_tag    = req_tag;
  assign bus32.kill       = kill & ~sel64;
  assign bus32.mem_gnt    = mem_gnt & ~sel64;
  assign bus32.mem_rvalid = mem_rvalid & ~sel64;
  assign bus32.mem_rdata  = mem_rdata[31:0];

  assign bus64.req_valid  = req_valid & sel64;
  assign bus64.req_store  = req_store;
  assign bus64.req_size   = req_size;
  assign bus64.req_signed = req_signed;
  assign bus64.req_addr   = req_addr;
  assign bus64.req_wdata  = req_wdata;
  assign bus64.req_tag    = req_tag;
  assign bus64.kill       = kill & sel64;
  assign bus64.mem_gnt    = mem_gnt & sel64;
  assign bus64.mem_rvalid = mem_rvalid & sel64;
  assign bus64.mem_rdata  = mem_rdata;

  logic        obs_ready, obs_mem_req, obs_rsp_valid;
  logic [31:0] obs_mem_addr;
  logic [7:0]  obs_mem_we;
  logic [63:0] obs_mem_wdata, obs_rsp_data;
  logic [4:0]  obs_rsp_tag;

  assign obs_ready     = sel64 ? bus64.req_ready : bus32.req_ready;
  assign obs_mem_req   = sel64 ? bus64.mem_req   : bus32.mem_req;
  assign obs_mem_addr  = sel64 ? bus64.mem_addr  : bus32.mem_addr;
  assign obs_mem_we    = sel64 ? bus64.mem_we    : {4'b0, bus32.mem_we};
  assign obs_mem_wdata = sel64 ? bus64.mem_wdata : {32'b0, bus32.mem_wdata};
  assign obs_rsp_valid = sel64 ? bus64.rsp_valid : bus32.rsp_valid;
  assign obs_rsp_data  = sel64 ? bus64.rsp_data  : {32'b0, bus32.rsp_data};
  assign obs_rsp_tag   = sel64 ? bus64.rsp_tag   : bus32.rsp_tag;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"},     obs_ready, 64'd1);
    checkOutput({tag, "_mem_req"},   obs_mem_req, 64'd0);
    checkOutput({tag, "_mem_addr"},  obs_mem_addr, 64'd0);
    checkOutput({tag, "_mem_we"},    obs_mem_we, 64'd0);
    checkOutput({tag, "_mem_wdata"}, obs_mem_wdata, 64'd0);
    checkOutput({tag, "_rsp_valid"}, obs_rsp_valid, 64'd0);
    checkOutput({tag, "_rsp_data"},  obs_rsp_data, 64'd0);
    checkOutput({tag, "_rsp_tag"},   obs_rsp_tag, 64'd0);
  endtask

  // Drives one access end to end; the expected beats and result are derived from byte addresses.
  task automatic applyStimulus(input bit store, input logic [1:0] size, input bit sgn,
                               input logic [31:0] addr, input logic [63:0] wdata,
                               input logic [4:0] tag, input int gnt_dly, input int rd_lat,
                               input bit fixed, input logic [63:0] rd0, input logic [63:0] rd1,
                               output logic [63:0] got);
    int          nb, n, o, nbeats;
    logic [31:0] base, beat_addr, a, d;
    logic [7:0]  exp_we;
    logic [63:0] exp_wd, rdata, exp_rsp;
    logic [7:0]  res_bytes [8];
    nb = sel64 ? 8 : 4;
    n  = 1 << size;
    o  = int'(addr % nb);
    base = addr - o;
    nbeats = (o + n > nb) ? 2 : 1;
    for (int k = 0; k < 8; k++) res_bytes[k] = 8'h00;
    checkOutput("ready_before_req", obs_ready, 64'd1);
    req_valid = 1'b1; req_store = store; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata; req_tag = tag;
    tick();
    req_valid = 1'b0;
    if (n > nb) begin
      checkOutput("illegal_mem_req", obs_mem_req, 64'd0);
      checkOutput("illegal_rsp_valid", obs_rsp_valid, 64'd1);
      checkOutput("illegal_rsp_data", obs_rsp_data, 64'd0);
      checkOutput("illegal_rsp_tag", obs_rsp_tag, 64'(tag));
      got = obs_rsp_data;
      tick();
      checkOutput("illegal_rsp_drop", obs_rsp_valid, 64'd0);
      return;
    end
    for (int b = 0; b < nbeats; b++) begin
      beat_addr = base + 32'(b * nb);
      exp_we = '0;
      exp_wd = '0;
      for (int j = 0; j < nb; j++) begin
        a = beat_addr + 32'(j);
        d = a - addr;
        if (store && d < 32'(n)) begin
          exp_we[j] = 1'b1;
          exp_wd[8*j +: 8] = wdata[8*d +: 8];
        end
      end
      checkOutput("beat_req", obs_mem_req, 64'd1);
      checkOutput("beat_ready_low", obs_ready, 64'd0);
      checkOutput("beat_addr", obs_mem_addr, 64'(beat_addr));
      checkOutput("beat_we", obs_mem_we, 64'(exp_we));
      checkOutput("beat_wdata", obs_mem_wdata, exp_wd);
      repeat (gnt_dly) tick();
      checkOutput("beat_hold_addr", obs_mem_addr, 64'(beat_addr));
      checkOutput("beat_hold_we", obs_mem_we, 64'(exp_we));
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      if (!store) begin
        repeat (rd_lat) tick();
        rdata = fixed ? (b == 0 ? rd0 : rd1) : {$urandom, $urandom};
        for (int j = 0; j < nb; j++) begin
          a = beat_addr + 32'(j);
          d = a - addr;
          if (d < 32'(n)) res_bytes[d] = rdata[8*j +: 8];
        end
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0;
      end
    end
    exp_rsp = '0;
    if (!store) begin
      for (int k = 0; k < n; k++) exp_rsp[8*k +: 8] = res_bytes[k];
      if (sgn && res_bytes[n-1][7]) begin
        for (int k = n; k < nb; k++) exp_rsp[8*k +: 8] = 8'hFF;
      end
    end
    checkOutput("rsp_valid", obs_rsp_valid, 64'd1);
    checkOutput("rsp_data", obs_rsp_data, exp_rsp);
    checkOutput("rsp_tag", obs_rsp_tag, 64'(tag));
    got = obs_rsp_data;
    tick();
    checkOutput("rsp_pulse_end", obs_rsp_valid, 64'd0);
    checkOutput("ready_after_rsp", obs_ready, 64'd1);
  endtask

  initial begin
    logic [63:0] got;
    rst_n = 1'b0; sel64 = 1'b0;
    req_valid = 1'b0; req_store = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; req_tag = '0; kill = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) tick();
    checkResetState("reset32");
    sel64 = 1'b1;
    checkResetState("reset64");
    sel64 = 1'b0;
    rst_n = 1'b1;
    tick();

    // Aligned word store and the split word store from the directed examples.
    applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h100, 64'hDEADBEEF, 5'd1, 0, 0, 1'b0, '0, '0, got);
    applyStimulus(1'b1, SZ_WORD, 1'b0, 32'h103, 64'h11223344, 5'd2, 1, 0, 1'b0, '0, '0, got);

    applyStimulus(1'b0, SZ_HALF, 1'b1, 32'h203, '0, 5'd3, 0, 0, 1'b1,
                  64'hFF000000, 64'h00000080, got);
    checkOutput("t3_signed", got, 64'hFFFF80FF);
    applyStimulus(1'b0, SZ_HALF, 1'b0, 32'h203, '0, 5'd4, 0, 1, 1'b1,
                  64'hFF000000, 64'h00000080, got);
    checkOutput("t3_unsigned", got, 64'h000080FF);

    applyStimulus(1'b0, SZ_DWORD, 1'b0, 32'h10, '0, 5'd5, 0, 0, 1'b0, '0, '0, got);
    checkOutput("illegal_size_zero", got, 64'd0);

    // kill while idle: the offer must be refused
    req_valid = 1'b1; req_store = 1'b1; req_size = SZ_WORD; req_addr = 32'h100; kill = 1'b1;
    tick();
    req_valid = 1'b0; kill = 1'b0;
    checkOutput("kill_idle_req", obs_mem_req, 64'd0);
    checkOutput("kill_idle_ready", obs_ready, 64'd1);

    // kill in BEAT0 before any grant aborts silently
    req_valid = 1'b1; req_tag = 5'd6;
    tick();
    req_valid = 1'b0;
    checkOutput("kill_b0_req_up", obs_mem_req, 64'd1);
    kill = 1'b1;
    tick();
    kill = 1'b0;
    checkOutput("kill_b0_req", obs_mem_req, 64'd0);
    checkOutput("kill_b0_ready", obs_ready, 64'd1);
    checkOutput("kill_b0_rsp", obs_rsp_valid, 64'd0);
    tick();
    checkOutput("kill_b0_rsp_late", obs_rsp_valid, 64'd0);

    // split store killed in BEAT1: the second beat still completes, no response
    req_valid = 1'b1; req_store = 1'b1; req_size = SZ_WORD; req_addr = 32'h103;
    req_wdata = 64'h11223344; req_tag = 5'd7;
    tick();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    kill = 1'b1;
    checkOutput("t4_b1_addr", obs_mem_addr, 64'h104);
    checkOutput("t4_b1_we", obs_mem_we, 64'h7);
    checkOutput("t4_b1_wdata", obs_mem_wdata, 64'h00112233);
    tick();
    kill = 1'b0;
    repeat (2) tick();
    checkOutput("t4_b1_held", obs_mem_req, 64'd1);
    checkOutput("t4_b1_held_addr", obs_mem_addr, 64'h104);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    checkOutput("t4_req_done", obs_mem_req, 64'd0);
    checkOutput("t4_no_rsp", obs_rsp_valid, 64'd0);
    checkOutput("t4_ready", obs_ready, 64'd1);
    tick();
    checkOutput("t4_no_rsp_late", obs_rsp_valid, 64'd0);

    // load killed while waiting for data: drains, then no response
    req_valid = 1'b1; req_store = 1'b0; req_size = SZ_WORD; req_addr = 32'h300; req_tag = 5'd8;
    tick();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    kill = 1'b1;
    tick();
    kill = 1'b0;
    checkOutput("kill_ld_wait_ready", obs_ready, 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 64'h12345678;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("kill_ld_no_rsp", obs_rsp_valid, 64'd0);
    checkOutput("kill_ld_ready", obs_ready, 64'd1);

    // reset while waiting for load data, then a stale rvalid
    req_valid = 1'b1; req_addr = 32'h400; req_tag = 5'd9;
    tick();
    req_valid = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkResetState("rst_wait");
    mem_rvalid = 1'b1; mem_rdata = 64'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("stale_rv_rsp", obs_rsp_valid, 64'd0);
    checkOutput("stale_rv_ready", obs_ready, 64'd1);
    applyStimulus(1'b0, SZ_WORD, 1'b1, 32'h401, '0, 5'd10, 0, 0, 1'b0, '0, '0, got);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    32'h100 + 32'($urandom_range(0, 255)), {$urandom, $urandom},
                    5'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    1'b0, '0, '0, got);
    end

    sel64 = 1'b1;
    applyStimulus(1'b0, SZ_DWORD, 1'b0, 32'h1004, '0, 5'd11, 0, 0, 1'b1,
                  64'h8877665544332211, 64'h00FFEEDDCCBBAA99, got);
    checkOutput("t5_dword", got, 64'hCCBBAA9988776655);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    32'h2000 + 32'($urandom_range(0, 255)), {$urandom, $urandom},
                    5'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                    1'b0, '0, '0, got);
    end
    sel64 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
